// File: rtl/aes_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctrl_pkg
//  Description : Shared types and constants for the AES round sequencer:
//                FSM state encoding, key-size encoding and the round count
//                associated with each key size.
//  Revision    : 1.0 - initial parametrised 128/192/256 enc/dec release
// ============================================================================
package aes_ctrl_pkg;

    // Sequencer states. KEXP is only visited on the decrypt path.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Key-size field as presented on key_mode; KILL is the illegal code.
    typedef enum logic [1:0] {
        K128 = 2'b00,
        K192 = 2'b01,
        K256 = 2'b10,
        KILL = 2'b11
    } keysz_e;

    // Number of cipher rounds per key size.
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    // Round count for a key size. The illegal code maps to the AES-128
    // count; callers reject that code before the result is ever latched.
    function automatic int unsigned nr_of(input keysz_e ks);
        case (ks)
            K128:    return NR_128;
            K192:    return NR_192;
            K256:    return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl_if
//  Description : Control/status bundle between the AES core datapath
//                (master) and the round sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if #(
    parameter int MAX_ROUNDS = 14,
    parameter int RNDW       = $clog2(MAX_ROUNDS + 1)
);

    // Requests from the core
    logic                  start;
    logic [1:0]            key_mode;
    logic                  decrypt;
    logic                  abort;
    logic                  core_stall;

    // Sequencer status
    logic                  accept;
    logic                  busy;
    logic                  inv;
    logic [RNDW-1:0]       rnd_no;
    logic [RNDW-1:0]       key_idx;
    logic                  done;
    logic                  err;
    logic [MAX_ROUNDS-1:0] completed_round;

    // Per-round stage enables
    logic                  enb_sb;
    logic                  enb_sr;
    logic                  enb_mc;
    logic                  enb_ar;
    logic                  enb_ks;

    // Core / datapath side
    modport master (
        output start, key_mode, decrypt, abort, core_stall,
        input  accept, busy, inv, rnd_no, key_idx, done, err, completed_round,
        input  enb_sb, enb_sr, enb_mc, enb_ar, enb_ks
    );

    // Sequencer side
    modport slave (
        input  start, key_mode, decrypt, abort, core_stall,
        output accept, busy, inv, rnd_no, key_idx, done, err, completed_round,
        output enb_sb, enb_sr, enb_mc, enb_ar, enb_ks
    );

endinterface : aes_round_ctrl_if
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : AES round sequencer. Steps the core through Nr rounds for
//                128/192/256-bit keys, encrypt or decrypt. Decrypt first runs
//                a forward key-expansion pass (KEXP) and then walks the round
//                keys backwards. Provides stall, abort and illegal-mode error.
//  Revision    : 1.0 - successor to the fixed AES-128 encrypt-only controller
// ============================================================================
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int MAX_ROUNDS  = 14,
    parameter int RNDW        = $clog2(MAX_ROUNDS + 1),
    parameter bit SUPPORT_DEC = 1'b1
) (
    input  wire             clk,
    input  wire             rstn,
    aes_round_ctrl_if.slave bus
);

    // ------------------------------------------------------------------------
    // State encoding (kept as plain vectors for compatibility with existing
    // netlist tooling; values track the package enum)
    // ------------------------------------------------------------------------
    localparam logic [1:0]      c_ST_IDLE  = IDLE;
    localparam logic [1:0]      c_ST_KEXP  = KEXP;
    localparam logic [1:0]      c_ST_RUN   = RUN;
    localparam logic [RNDW-1:0] c_NR_RESET = RNDW'(NR_128);
    localparam logic [RNDW-1:0] c_RND_ONE  = RNDW'(1);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [RNDW-1:0]       r_rnd;
    logic [RNDW-1:0]       w_rnd_nxt;
    logic [RNDW-1:0]       r_nr;
    logic [RNDW-1:0]       w_nr_nxt;
    logic                  r_inv;
    logic                  w_inv_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_err;
    logic                  w_err_nxt;

    // Decoded helpers
    keysz_e                w_keysz;
    logic [RNDW-1:0]       w_req_nr;
    logic                  w_dec_ok;
    logic                  w_start_legal;
    logic                  w_in_idle;
    logic                  w_in_kexp;
    logic                  w_in_run;
    logic                  w_rnd_nz;
    logic                  w_last;
    logic                  w_round_body;
    logic                  w_mix_round;
    logic [MAX_ROUNDS-1:0] w_completed;

    // ------------------------------------------------------------------------
    // Decrypt capability: with decrypt compiled out, a decrypt request is
    // handled like an illegal key mode.
    // ------------------------------------------------------------------------
    generate
        if (SUPPORT_DEC) begin : g_dec_on
            assign w_dec_ok = 1'b1;
        end else begin : g_dec_off
            assign w_dec_ok = 1'b0;
        end
    endgenerate

    assign w_keysz       = keysz_e'(bus.key_mode);
    assign w_req_nr      = RNDW'(nr_of(w_keysz));
    assign w_start_legal = (w_keysz != KILL) && (!bus.decrypt || w_dec_ok);

    assign w_in_idle     = (r_state == c_ST_IDLE);
    assign w_in_kexp     = (r_state == c_ST_KEXP);
    assign w_in_run      = (r_state == c_ST_RUN);
    assign w_rnd_nz      = (r_rnd != '0);
    assign w_last        = (r_rnd == r_nr);

    // Rounds 1..Nr carry SubBytes/ShiftRows; MixColumns skips the final round.
    assign w_round_body  = w_in_run && w_rnd_nz;
    assign w_mix_round   = w_round_body && (r_rnd < r_nr);

    // ------------------------------------------------------------------------
    // Next-state logic: abort beats stall, stall beats advance
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_nr_nxt    = r_nr;
        w_inv_nxt   = r_inv;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (bus.abort) begin
            // Kill in any state; a start in the same cycle is dropped.
            w_state_nxt = c_ST_IDLE;
            w_rnd_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Stall has no meaning while idle.
                    if (bus.start) begin
                        if (w_start_legal) begin
                            w_nr_nxt    = w_req_nr;
                            w_inv_nxt   = bus.decrypt;
                            w_rnd_nxt   = c_RND_ONE;
                            w_state_nxt = bus.decrypt ? c_ST_KEXP : c_ST_RUN;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end
                end

                c_ST_KEXP: begin
                    // Forward expansion 1..Nr, then decrypt round 0 in RUN.
                    if (!bus.core_stall) begin
                        if (w_last) begin
                            w_state_nxt = c_ST_RUN;
                            w_rnd_nxt   = '0;
                        end else begin
                            w_rnd_nxt   = r_rnd + c_RND_ONE;
                        end
                    end
                end

                c_ST_RUN: begin
                    if (!bus.core_stall) begin
                        if (w_last) begin
                            w_state_nxt = c_ST_IDLE;
                            w_rnd_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_rnd_nxt   = r_rnd + c_RND_ONE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_rnd_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers; reset drops straight back to idle with no done pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
            r_rnd   <= '0;
            r_nr    <= c_NR_RESET;
            r_inv   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_nr    <= w_nr_nxt;
            r_inv   <= w_inv_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // One-hot marker of the round currently being finished (rnd_no-1)
    // ------------------------------------------------------------------------
    always_comb begin
        w_completed = '0;
        if (w_round_body) begin
            for (int i = 0; i < MAX_ROUNDS; i++) begin
                if (r_rnd == RNDW'(i + 1)) begin
                    w_completed[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.accept          = w_in_idle;
    assign bus.busy            = !w_in_idle;
    assign bus.inv             = r_inv;
    assign bus.rnd_no          = r_rnd;
    assign bus.done            = r_done;
    assign bus.err             = r_err;
    assign bus.completed_round = w_completed;

    // Decrypt walks the schedule backwards; r_rnd never exceeds r_nr so the
    // subtraction cannot wrap. Idle always reports index 0.
    assign bus.key_idx         = (r_inv && !w_in_idle) ? (r_nr - r_rnd) : r_rnd;

    // Idle doubles as encrypt round 0 (initial AddRoundKey); KEXP only
    // expands keys; RUN applies the full round pipeline.
    assign bus.enb_sb          = w_round_body;
    assign bus.enb_sr          = w_round_body;
    assign bus.enb_mc          = w_mix_round;
    assign bus.enb_ar          = w_in_idle || w_in_run;
    assign bus.enb_ks          = w_in_kexp || (w_round_body && !r_inv);

endmodule : aes_round_ctrl
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Self-checking bench for aes_round_ctrl. Directed blocks with
//                hand-derived latencies; done/err pulses are scored against a
//                queue of expected pulses by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    typedef struct {
        bit is_err;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   g_inv    = 1'b0;
    exp_t sb_q[$];

    aes_round_ctrl_if #(.MAX_ROUNDS(14)) bus ();

    aes_round_ctrl #(
        .MAX_ROUNDS (14),
        .SUPPORT_DEC(1'b1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] snap();
        return {2'b00, bus.rnd_no, bus.key_idx, bus.enb_sb, bus.enb_sr, bus.enb_mc,
                bus.enb_ar, bus.enb_ks, bus.accept, bus.busy, bus.inv, bus.completed_round};
    endfunction

    // Expected output vector. ph: 0 idle, 1 key expansion, 2 rounds.
    function automatic logic [31:0] model(input int ph, input int er, input int nr, input bit inv);
        logic [3:0]  r4;
        logic [3:0]  k4;
        logic        sb, mc, ar, ks;
        logic [13:0] comp;
        r4   = 4'(er);
        k4   = (ph != 0 && inv) ? 4'(nr - er) : 4'(er);
        sb   = (ph == 2) && (er >= 1);
        mc   = (ph == 2) && (er >= 1) && (er < nr);
        ar   = (ph != 1);
        ks   = (ph == 1) || ((ph == 2) && !inv && (er >= 1));
        comp = ((ph == 2) && (er >= 1)) ? (14'd1 << (er - 1)) : 14'd0;
        return {2'b00, r4, k4, sb, sb, mc, ar, ks, (ph == 0), (ph != 0), inv, comp};
    endfunction

    // Monitor: scores every done/err pulse against the expected queue.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_pulse cyc=%0d got=none want=%s@%0d", cyc, e.is_err ? "err" : "done", e.cyc);
        end
        if (rstn === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse cyc=%0d got=done%0b/err%0b want=none", cyc, bus.done, bus.err);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || bus.err !== e.is_err || bus.done !== !e.is_err) begin
                    n_errors++;
                    $display("FAIL pulse cyc=%0d got=done%0b/err%0b want=%s@%0d",
                             cyc, bus.done, bus.err, e.is_err ? "err" : "done", e.cyc);
                end
            end
        end
    end

    // Issue one block at the current cycle and follow it cycle by cycle.
    // Returns positioned at the done cycle, before its sampling edge.
    task automatic do_block(input logic [1:0] km, input bit dec, input int nr, input int lat,
                            input int stall_rnd, input int stall_len, input bit poke);
        int ph, er, sl, t;
        bit stall;
        bus.start    = 1'b1;
        bus.key_mode = km;
        bus.decrypt  = dec;
        sb_q.push_back('{1'b0, cyc + lat});
        @(negedge clk);
        check("t0_idle", snap(), model(0, 0, nr, g_inv));
        g_inv = dec;
        ph = dec ? 1 : 2;
        er = 1;
        sl = stall_len;
        t  = 1;
        step();
        bus.start = 1'b0;
        while (ph != 0 && t < lat + 8) begin
            stall = (ph == 2) && (er == stall_rnd) && (sl > 0);
            bus.core_stall = stall;
            if (poke && (t == 3 || t == 4)) begin
                bus.start    = 1'b1;
                bus.key_mode = 2'b11;
            end else begin
                bus.start    = 1'b0;
            end
            @(negedge clk);
            check("trace", snap(), model(ph, er, nr, dec));
            if (stall) sl--;
            else if (er == nr) begin
                if (ph == 1) begin ph = 2; er = 0; end
                else ph = 0;
            end else er++;
            step();
            t++;
        end
        bus.core_stall = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check(name, snap(), model(0, 0, 0, g_inv));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.key_mode   = 2'b00;
        bus.decrypt    = 1'b0;
        bus.abort      = 1'b0;
        bus.core_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", snap(), model(0, 0, 10, 1'b0));
        check("reset_pulses", {30'd0, bus.done, bus.err}, 32'd0);
        step();
        rstn = 1'b1;
        step();

        // 1: encrypt 128, done 11 cycles after start
        do_block(2'b00, 1'b0, 10, 11, 0, 0, 1'b0);
        idle_check("enc128_accept_at_done");

        // 2: encrypt 256 (done +15), then decrypt 192 back-to-back (done +26)
        do_block(2'b10, 1'b0, 14, 15, 0, 0, 1'b0);
        do_block(2'b01, 1'b1, 12, 26, 0, 0, 1'b0);
        idle_check("dec192_idle");

        // 3: three stall cycles at round 5 push done to +14
        do_block(2'b00, 1'b0, 10, 14, 5, 3, 1'b0);
        idle_check("stall_idle");

        // 4a: abort at round 7
        bus.start = 1'b1; bus.key_mode = 2'b00; bus.decrypt = 1'b0;
        g_inv = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check("abort_at_rnd7", {28'd0, bus.rnd_no}, 32'd7);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        idle_check("abort_idle");

        // 4b: abort together with stall during decrypt key expansion
        bus.start = 1'b1; bus.key_mode = 2'b10; bus.decrypt = 1'b1;
        g_inv = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.abort = 1'b1; bus.core_stall = 1'b1;
        step();
        bus.abort = 1'b0; bus.core_stall = 1'b0;
        idle_check("abort_stall_idle");

        // 4c: abort with start in idle drops the start (inv stays latched)
        bus.start = 1'b1; bus.key_mode = 2'b00; bus.decrypt = 1'b0; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        idle_check("abort_start_ignored");
        do_block(2'b00, 1'b0, 10, 11, 0, 0, 1'b0);
        idle_check("after_abort_idle");

        // 5: illegal mode gives err next cycle and stays idle
        bus.start = 1'b1; bus.key_mode = 2'b11; bus.decrypt = 1'b0;
        sb_q.push_back('{1'b1, cyc + 1});
        step();
        bus.start = 1'b0;
        idle_check("illegal_stays_idle");
        // start pokes while busy are ignored; next block starts on done cycle
        do_block(2'b01, 1'b0, 12, 13, 0, 0, 1'b1);
        do_block(2'b00, 1'b0, 10, 11, 0, 0, 1'b0);
        idle_check("b2b_idle");

        // 6: asynchronous reset in the middle of a run
        bus.start = 1'b1; bus.key_mode = 2'b00; bus.decrypt = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        #2;
        rstn = 1'b0;
        #1;
        g_inv = 1'b0;
        check("async_reset", snap(), model(0, 0, 10, 1'b0));
        check("async_reset_pulses", {30'd0, bus.done, bus.err}, 32'd0);
        step();
        rstn = 1'b1;
        do_block(2'b00, 1'b0, 10, 11, 0, 0, 1'b0);
        idle_check("post_reset_idle");

        repeat (4) step();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_aes_round_ctrl
`default_nettype wire
